// File: rtl/alu_addsub_pipe.sv
// ---------------------------------------------------------------------------
// alu_addsub_pipe
//   Two-stage pipelined signed add/subtract unit with an accumulator mode,
//   optional saturation to the N-bit signed range and registered status flags.
//
// Handshake: a transfer happens on a port in any cycle where valid && ready
//   are both high at the rising edge. A producer holds its payload stable
//   while valid is high and ready is low. in_ready is combinational from
//   out_ready, so a full pipeline can accept a new input in the same cycle
//   that the downstream takes a result.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      asynchronous, active-high reset
//   in_valid   input transaction present
//   in_ready   block can accept the input this cycle
//   a, b       signed N-bit operands (b ignored for op 10/11)
//   op         00 a-b, 01 a+b, 10 acc+a, 11 load acc with a
//   sat        1 = clamp result to the N-bit signed range
//   out_valid  result present
//   out_ready  downstream accepts the result this cycle
//   ans        signed N+1-bit result
//   ovf        overflow (op 10 wrap) or clamp flag
//   zero       ans == 0
//   neg        ans sign bit
// ---------------------------------------------------------------------------
module alu_addsub_pipe #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [1:0]   op,
   input  logic         sat,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N:0]   ans,
   output logic         ovf,
   output logic         zero,
   output logic         neg
);

   // Internal arithmetic width: one guard bit above the N+1-bit result so
   // that acc+a under saturation never wraps before it is clamped.
   localparam int W = N + 2;

   localparam logic signed [W-1:0] SAT_MAX_W = {{3{1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [W-1:0] SAT_MIN_W = {{3{1'b1}}, {(N-1){1'b0}}};
   localparam logic [N:0]          SAT_MAX   = {2'b00, {(N-1){1'b1}}};
   localparam logic [N:0]          SAT_MIN   = {2'b11, {(N-1){1'b0}}};

   localparam logic [1:0] OP_SUB  = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_ACC  = 2'b10;

   // Stage 1 registers
   logic         s1_valid_q, s1_valid_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic [1:0]   op_q, op_d;
   logic         sat_q, sat_d;

   // Stage 2 registers
   logic         out_valid_q, out_valid_d;
   logic [N:0]   ans_q, ans_d;
   logic         ovf_q, ovf_d;
   logic         zero_q, zero_d;
   logic         neg_q, neg_d;
   logic [N:0]   acc_q, acc_d;

   logic         s2_load;
   logic         in_xfer;

   logic signed [W-1:0] a_x, b_x, acc_x, raw_x;
   logic [N:0]          res;
   logic                res_ovf;

   // Handshake
   always_comb begin
      s2_load  = s1_valid_q && (!out_valid_q || out_ready);
      in_ready = !s1_valid_q || s2_load;
      in_xfer  = in_valid && in_ready;
   end

   // Arithmetic on the stage-1 registers
   always_comb begin
      a_x     = {{2{a_q[N-1]}}, a_q};
      b_x     = {{2{b_q[N-1]}}, b_q};
      acc_x   = {acc_q[N], acc_q};
      raw_x   = a_x;
      res     = '0;
      res_ovf = 1'b0;

      case (op_q)
         OP_SUB:  raw_x = a_x - b_x;
         OP_ADD:  raw_x = a_x + b_x;
         OP_ACC:  raw_x = acc_x + a_x;
         default: raw_x = a_x;
      endcase

      if (sat_q) begin
         if (raw_x > SAT_MAX_W) begin
            res     = SAT_MAX;
            res_ovf = 1'b1;
         end else if (raw_x < SAT_MIN_W) begin
            res     = SAT_MIN;
            res_ovf = 1'b1;
         end else begin
            res     = raw_x[N:0];
         end
      end else begin
         // Only acc+a can leave the N+1-bit range; sub/add of N-bit values fit.
         res = raw_x[N:0];
         if (op_q == OP_ACC)
            res_ovf = (acc_q[N] == a_q[N-1]) && (raw_x[N] != acc_q[N]);
      end
   end

   // Next-state logic
   always_comb begin
      s1_valid_d  = s1_valid_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      sat_d       = sat_q;
      out_valid_d = out_valid_q;
      ans_d       = ans_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      neg_d       = neg_q;
      acc_d       = acc_q;

      if (in_xfer) begin
         s1_valid_d = 1'b1;
         a_d        = a;
         b_d        = b;
         op_d       = op;
         sat_d      = sat;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end

      if (s2_load) begin
         out_valid_d = 1'b1;
         ans_d       = res;
         ovf_d       = res_ovf;
         zero_d      = (res == '0);
         neg_d       = res[N];
         if (op_q[1])
            acc_d = res;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         ans_q       <= '0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         acc_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
         ans_q       <= ans_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         acc_q       <= acc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign ans       = ans_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign neg       = neg_q;

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_addsub_pipe
//   Bench for alu_addsub_pipe at N=4: directed scenarios with literal
//   expectations, then randomized traffic with random backpressure, all
//   checked against an integer reference model and an expected queue.
// ---------------------------------------------------------------------------
module tb_alu_addsub_pipe;
   localparam int N = 4;

   typedef logic [N+3:0] rec_t;  // {ans, ovf, zero, neg}

   logic                clk = 1'b0;
   logic                reset;
   logic                in_valid;
   logic                in_ready;
   logic signed [N-1:0] a;
   logic signed [N-1:0] b;
   logic [1:0]          op;
   logic                sat;
   logic                out_valid;
   logic                out_ready;
   logic [N:0]          ans;
   logic                ovf;
   logic                zero;
   logic                neg;

   rec_t exp_q[$];
   rec_t got_q[$];
   int   model_acc;
   int   n_cmp;
   int   n_fail;
   bit   rnd_done;

   alu_addsub_pipe #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .sat       (sat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ans       (ans),
      .ovf       (ovf),
      .zero      (zero),
      .neg       (neg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   function automatic rec_t pk(input int v, input bit o, input bit z, input bit n);
      logic [31:0] t;
      t = v;
      return {t[N:0], o, z, n};
   endfunction

   function automatic rec_t model(input logic [1:0] o, input int av, input int bv,
                                  input bit s, input int acc_in, output int acc_out);
      int raw, res, lo, hi;
      bit f;
      lo = -(1 << (N-1));
      hi = (1 << (N-1)) - 1;
      case (o)
         2'd0:    raw = av - bv;
         2'd1:    raw = av + bv;
         2'd2:    raw = acc_in + av;
         default: raw = av;
      endcase
      res = raw;
      f   = 1'b0;
      if (s) begin
         if (raw > hi) begin res = hi; f = 1'b1; end
         else if (raw < lo) begin res = lo; f = 1'b1; end
      end else begin
         if (raw > (1 << N) - 1) begin res = raw - (1 << (N+1)); f = 1'b1; end
         else if (raw < -(1 << N)) begin res = raw + (1 << (N+1)); f = 1'b1; end
      end
      acc_out = (o >= 2'd2) ? res : acc_in;
      return pk(res, f, res == 0, res < 0);
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input rec_t got, input rec_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got {ans,ovf,zero,neg}=%h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic expect_got(input string name, input rec_t exp);
      if (got_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s got no result expected %h", name, exp);
      end else begin
         check(name, got_q.pop_front(), exp);
      end
   endtask

   // Compare process: every cycle with a result present, the DUT must show
   // the oldest outstanding expectation (this also covers stability under stall).
   always @(negedge clk) begin
      int nacc;
      if (!reset) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_output got ans=%h expected none at %0t", ans, $time);
            end else begin
               check("stream", {ans, ovf, zero, neg}, exp_q[0]);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  got_q.push_back({ans, ovf, zero, neg});
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(op, int'(a), int'(b), sat, model_acc, nacc));
            model_acc = nacc;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [1:0] o, input int av, input int bv, input bit s);
      bit acc;
      int k;
      op       = o;
      a        = av[N-1:0];
      b        = bv[N-1:0];
      sat      = s;
      in_valid = 1'b1;
      acc      = 1'b0;
      for (k = 0; k < 200 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout got in_ready=0 expected 1 within 200 cycles");
      end
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 100 && exp_q.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int tmp;
      int accepted;
      int nxt;
      reset     = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      op        = 2'b00;
      sat       = 1'b0;
      out_ready = 1'b1;
      model_acc = 0;
      n_cmp     = 0;
      n_fail    = 0;
      rnd_done  = 1'b0;

      // Model pins
      check("pin_add_sat",  model(2'd1, 7, 7, 1'b1, 0, tmp),   pk(7, 1, 0, 0));
      check("pin_sub_raw",  model(2'd0, -8, 7, 1'b0, 0, tmp),  pk(-15, 0, 0, 1));
      check("pin_acc_wrap", model(2'd2, 7, 0, 1'b0, 12, tmp),  pk(-13, 1, 0, 1));

      repeat (2) @(posedge clk);
      #3;
      check("reset_state", {ans, ovf, zero, neg}, pk(0, 0, 0, 0));
      chk1("reset_out_valid", out_valid, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      chk1("in_ready_after_reset", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // 1: saturation on add, with latency check
      got_q.delete();
      send(2'd1, 7, 7, 1'b0);
      @(negedge clk);
      chk1("latency_cycle1", out_valid, 1'b0);
      @(negedge clk);
      chk1("latency_cycle2", out_valid, 1'b1);
      @(posedge clk);
      #1;
      send(2'd1, 7, 7, 1'b1);
      drain();
      expect_got("add_nosat", pk(14, 0, 0, 0));
      expect_got("add_sat",   pk(7, 1, 0, 0));

      // 2: saturation on subtract
      send(2'd0, -8, 7, 1'b0);
      send(2'd0, -8, 7, 1'b1);
      drain();
      expect_got("sub_nosat", pk(-15, 0, 0, 1));
      expect_got("sub_sat",   pk(-8, 1, 0, 1));

      // 3: accumulator chain back-to-back, wrap then saturate
      send(2'd3, 5, 0, 1'b0);
      send(2'd2, 7, 0, 1'b0);
      send(2'd2, 7, 0, 1'b0);
      send(2'd3, 5, 0, 1'b1);
      send(2'd2, 7, 0, 1'b1);
      send(2'd2, 7, 0, 1'b1);
      drain();
      expect_got("acc_load",     pk(5, 0, 0, 0));
      expect_got("acc_add1",     pk(12, 0, 0, 0));
      expect_got("acc_wrap",     pk(-13, 1, 0, 1));
      expect_got("acc_sat_load", pk(5, 0, 0, 0));
      expect_got("acc_sat_add1", pk(7, 1, 0, 0));
      expect_got("acc_sat_add2", pk(7, 1, 0, 0));

      // 4: backpressure, payload held until accepted
      out_ready = 1'b0;
      accepted  = 0;
      nxt       = 1;
      op        = 2'd1;
      sat       = 1'b0;
      b         = 4'sd1;
      a         = 4'sd1;
      in_valid  = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (in_ready) accepted++;
         @(posedge clk);
         #1;
         if (accepted == nxt) begin
            nxt++;
            a = nxt[N-1:0];
         end
      end
      tmp = accepted;
      check("bp_accept_count", rec_t'(tmp), rec_t'(2));
      @(negedge clk);
      chk1("bp_in_ready_low", in_ready, 1'b0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();
      expect_got("bp_res0", pk(2, 0, 0, 0));
      expect_got("bp_res1", pk(3, 0, 0, 0));
      expect_got("bp_res2", pk(4, 0, 0, 0));
      check("bp_no_extra", rec_t'(got_q.size()), rec_t'(0));

      // 5: reset mid-stream with ACC=12 and a stage-1 transaction pending
      send(2'd3, 5, 0, 1'b0);
      send(2'd2, 7, 0, 1'b0);
      drain();
      got_q.delete();
      send(2'd1, 1, 1, 1'b0);
      #2;
      reset = 1'b1;
      exp_q.delete();
      model_acc = 0;
      #1;
      chk1("midreset_out_valid", out_valid, 1'b0);
      check("midreset_outputs", {ans, ovf, zero, neg}, pk(0, 0, 0, 0));
      @(posedge clk);
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;
      got_q.delete();
      send(2'd2, 3, 0, 1'b0);
      drain();
      expect_got("post_reset_acc", pk(3, 0, 0, 0));

      // 6: flags
      send(2'd0, 3, 3, 1'b0);
      send(2'd0, 2, 3, 1'b0);
      drain();
      expect_got("flag_zero", pk(0, 0, 1, 0));
      expect_got("flag_neg",  pk(-1, 0, 0, 1));

      // Randomized traffic with random idle cycles and random backpressure
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)) - 8,
                    int'($urandom_range(0, 15)) - 8, 1'($urandom_range(0, 1)));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               out_ready = ($urandom_range(0, 2) != 0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
